// File: rtl/eros_pkg.sv
// Shared types and default constants for the EROS on-chip RAM power sequencer.
package eros_pkg;

    localparam int unsigned DEF_IDLE_CYCLES   = 1024;
    localparam int unsigned DEF_ACK_TIMEOUT   = 64;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        PWR_ON       = 3'd0,
        PWR_DRAIN    = 3'd1,
        PWR_RET      = 3'd2,
        PWR_OFF_WAIT = 3'd3,
        PWR_OFF      = 3'd4,
        PWR_ON_WAIT  = 3'd5,
        PWR_SETTLE   = 3'd6
    } mem_pwr_state_e;

    // OBI: a request is transferred in the cycle where req && gnt; the requester
    // holds req and its payload stable until gnt. rvalid/rdata follow later, one per transfer.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/eros_mem_pwr_bank_fsm.sv
// One RAM bank's power sequencer: OBI gating, drain, retention/power-gate handshake.
// EROS_MEM_PWR_AUTO_EN compiles in the idle counter and auto power-down trigger.
module eros_mem_pwr_bank_fsm
    import eros_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES   = DEF_IDLE_CYCLES,
    parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  obi_req_t   bank_req_i,
    output obi_resp_t  bank_resp_o,
    output obi_req_t   mem_req_o,
    input  obi_resp_t  mem_resp_i,
    output logic       pwrgate_no,
    input  logic       pwrgate_ack_ni,
    output logic       set_retentive_no,
    input  logic       sleep_req_i,
    input  logic       retain_i,
`ifdef EROS_MEM_PWR_AUTO_EN
    input  logic       auto_en_i,
`endif
    input  logic       err_clr_i,
    output logic [2:0] state_o,
    output logic       err_o
);

    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ACK_W-1:0] ACK_MAX     = ACK_W'(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST    = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    mem_pwr_state_e   state_q, state_d;
    logic [1:0]       outst_q;
    logic [ACK_W-1:0] ack_cnt_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic             pwrgate_q, ret_q, err_q;
    logic             pass_en, accept, retire, trigger, in_ack_wait;

    assign pass_en     = (state_q == PWR_ON);
    assign in_ack_wait = (state_q == PWR_OFF_WAIT) || (state_q == PWR_ON_WAIT);

    // Only req and gnt are gated; responses to already-granted requests keep flowing while draining.
    always_comb begin
        mem_req_o       = bank_req_i;
        mem_req_o.req   = bank_req_i.req & pass_en;
        bank_resp_o     = mem_resp_i;
        bank_resp_o.gnt = mem_resp_i.gnt & pass_en;
    end

    assign accept = mem_req_o.req & mem_resp_i.gnt;
    assign retire = mem_resp_i.rvalid;

`ifdef EROS_MEM_PWR_AUTO_EN
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
    logic [IDLE_W-1:0] idle_q;

    // Cleared outside ON so a freshly woken bank gets a full idle period.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !pass_en || bank_req_i.req) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    assign trigger = sleep_req_i | (auto_en_i & (idle_q == IDLE_MAX));
`else
    localparam int unsigned IDLE_CYCLES_UNUSED = IDLE_CYCLES;
    assign trigger = sleep_req_i;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PWR_ON:       if (trigger && !bank_req_i.req) state_d = PWR_DRAIN;
            PWR_DRAIN: begin
                if (bank_req_i.req && !sleep_req_i) begin
                    state_d = PWR_ON;
                end else if (outst_q == 2'd0) begin
                    state_d = retain_i ? PWR_RET : PWR_OFF_WAIT;
                end
            end
            PWR_RET:      if (bank_req_i.req || !sleep_req_i) state_d = PWR_SETTLE;
            PWR_OFF_WAIT: if (!pwrgate_ack_ni) state_d = PWR_OFF;
            PWR_OFF:      if (bank_req_i.req || !sleep_req_i) state_d = PWR_ON_WAIT;
            PWR_ON_WAIT:  if (pwrgate_ack_ni) state_d = PWR_SETTLE;
            PWR_SETTLE:   if (settle_cnt_q == SETTLE_LAST) state_d = PWR_ON;
            default:      state_d = PWR_ON;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= PWR_ON;
            pwrgate_q    <= 1'b1;
            ret_q        <= 1'b1;
            err_q        <= 1'b0;
            outst_q      <= 2'd0;
            ack_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pwrgate_q <= !((state_d == PWR_OFF_WAIT) || (state_d == PWR_OFF));
            ret_q     <= (state_d != PWR_RET);

            if (accept && !retire) begin
                outst_q <= outst_q + 2'd1;
            end else if (retire && !accept) begin
                outst_q <= outst_q - 2'd1;
            end

            if (!in_ack_wait) begin
                ack_cnt_q <= '0;
            end else if (ack_cnt_q != ACK_MAX) begin
                ack_cnt_q <= ack_cnt_q + 1'b1;
            end

            settle_cnt_q <= (state_q == PWR_SETTLE) ? settle_cnt_q + 1'b1 : '0;

            // Setting on the last wait cycle beats a simultaneous clear.
            if (in_ack_wait && (ack_cnt_q == ACK_LAST)) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign pwrgate_no       = pwrgate_q;
    assign set_retentive_no = ret_q;
    assign state_o          = state_q;
    assign err_o            = err_q;

endmodule

// File: rtl/eros_mem_pwr_ctrl.sv
// Per-bank power sequencer between the bus_system RAM ports and memory_sys.
// EROS_MEM_PWR_AUTO_EN enables idle auto power-down; otherwise auto_en_i is ignored.
module eros_mem_pwr_ctrl
    import eros_pkg::*;
#(
    parameter int unsigned N_BANKS       = 2,
    parameter int unsigned IDLE_CYCLES   = DEF_IDLE_CYCLES,
    parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  obi_req_t  [N_BANKS-1:0]     bank_req_i,
    output obi_resp_t [N_BANKS-1:0]     bank_resp_o,
    output obi_req_t  [N_BANKS-1:0]     mem_req_o,
    input  obi_resp_t [N_BANKS-1:0]     mem_resp_i,
    output logic      [N_BANKS-1:0]     pwrgate_no,
    input  logic      [N_BANKS-1:0]     pwrgate_ack_ni,
    output logic      [N_BANKS-1:0]     set_retentive_no,
    input  logic      [N_BANKS-1:0]     sleep_req_i,
    input  logic      [N_BANKS-1:0]     retain_i,
    input  logic                        auto_en_i,
    input  logic      [N_BANKS-1:0]     err_clr_i,
    output logic      [N_BANKS-1:0][2:0] bank_state_o,
    output logic      [N_BANKS-1:0]     err_o
);

`ifndef EROS_MEM_PWR_AUTO_EN
    logic auto_en_unused;
    assign auto_en_unused = auto_en_i;
`endif

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        eros_mem_pwr_bank_fsm #(
            .IDLE_CYCLES  (IDLE_CYCLES),
            .ACK_TIMEOUT  (ACK_TIMEOUT),
            .SETTLE_CYCLES(SETTLE_CYCLES)
        ) u_bank_fsm (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .bank_req_i      (bank_req_i[b]),
            .bank_resp_o     (bank_resp_o[b]),
            .mem_req_o       (mem_req_o[b]),
            .mem_resp_i      (mem_resp_i[b]),
            .pwrgate_no      (pwrgate_no[b]),
            .pwrgate_ack_ni  (pwrgate_ack_ni[b]),
            .set_retentive_no(set_retentive_no[b]),
            .sleep_req_i     (sleep_req_i[b]),
            .retain_i        (retain_i[b]),
`ifdef EROS_MEM_PWR_AUTO_EN
            .auto_en_i       (auto_en_i),
`endif
            .err_clr_i       (err_clr_i[b]),
            .state_o         (bank_state_o[b]),
            .err_o           (err_o[b])
        );
    end

endmodule
